// File: rtl/multi_channel_accumulator_pkg.sv
// Shared encodings and elaboration helpers for the multi-channel accumulator.
package multi_channel_accumulator_pkg;

  // Overflow handling mode, sampled on every update.
  localparam logic ACC_MODE_WRAP = 1'b0;
  localparam logic ACC_MODE_SAT  = 1'b1;

  // Sample operation.
  localparam logic ACC_OP_ADD = 1'b0;
  localparam logic ACC_OP_SUB = 1'b1;

  // Channel index width: at least one bit, even for a single channel.
  function automatic int ch_width(input int channels);
    int w;
    w = $clog2(channels);
    return (w < 1) ? 1 : w;
  endfunction

  // The accumulator needs one bit of headroom over the sample.
  function automatic bit acc_w_legal(input int data_w, input int acc_w);
    return acc_w >= data_w + 1;
  endfunction

endpackage

// File: rtl/multi_channel_accumulator_acc_lane.sv
// One accumulator channel: running-total register plus add/sub/saturate path.
module acc_lane
  import multi_channel_accumulator_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sub,
  input  logic              clr,
  input  logic              sat,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf_evt
);

  logic [ACC_W:0]   data_ext;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_nxt;

  // Widen by one bit so carry (add) and borrow (sub) both land in sum[ACC_W].
  always_comb begin
    data_ext = {{(ACC_W + 1 - DATA_W){1'b0}}, data};
    sum      = sub ? ({1'b0, acc} - data_ext) : ({1'b0, acc} + data_ext);
    carry    = sum[ACC_W];
    acc_nxt  = sum[ACC_W-1:0];
    if (carry && sat) begin
      acc_nxt = sub ? '0 : '1;
    end
    ovf_evt = en && !clr && carry;
  end

  // Running total: clear wins over the arithmetic update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? '0 : acc_nxt;
    end
  end

endmodule

// File: rtl/multi_channel_accumulator.sv
// N-channel unsigned accumulator with wrap/saturate overflow handling,
// sticky per-channel overflow flags and a registered result echo.
// Interface: in_valid is a one-cycle strobe with no back-pressure; every
// in_valid with an in-range in_ch is accepted, and out_valid pulses exactly
// one cycle later with the channel and its post-update total.
module multi_channel_accumulator
  import multi_channel_accumulator_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int DATA_W   = 4,
  parameter  int ACC_W    = 8,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_sub,
  input  logic                in_clr,
  input  logic                sat_en,
  input  logic                ovf_clr,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [ACC_W-1:0]    out_acc,
  output logic [CHANNELS-1:0] ovf
);

  if (!acc_w_legal(DATA_W, ACC_W)) begin : g_illegal_acc_w
    $error("multi_channel_accumulator: ACC_W must be at least DATA_W+1");
  end

  logic                in_range;
  logic                accept;
  logic [CHANNELS-1:0] lane_en;
  logic [CHANNELS-1:0] lane_ovf_evt;
  logic [ACC_W-1:0]    lane_acc [CHANNELS];
  logic [CHANNELS-1:0] ovf_nxt;

  // A power-of-two channel count makes every in_ch value legal.
  if (CHANNELS == (1 << CH_W)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = ({1'b0, in_ch} < (CH_W + 1)'(CHANNELS));
  end

  assign accept = in_valid && in_range;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign lane_en[i] = accept && (in_ch == CH_W'(i));

    acc_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .en      (lane_en[i]),
      .sub     (in_sub == ACC_OP_SUB),
      .clr     (in_clr),
      .sat     (sat_en == ACC_MODE_SAT),
      .data    (in_data),
      .acc     (lane_acc[i]),
      .ovf_evt (lane_ovf_evt[i])
    );
  end

  // Flag priority: global clear, then a fresh overflow sets, in_clr clears its bit.
  always_comb begin
    ovf_nxt = ovf_clr ? '0 : ovf;
    for (int i = 0; i < CHANNELS; i++) begin
      if (lane_ovf_evt[i]) begin
        ovf_nxt[i] = 1'b1;
      end else if (lane_en[i] && in_clr) begin
        ovf_nxt[i] = 1'b0;
      end
    end
  end

  // Sticky overflow flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= '0;
    end else begin
      ovf <= ovf_nxt;
    end
  end

  // Result strobe and channel tag; out_ch holds when nothing is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_ch <= in_ch;
      end
    end
  end

  // Reported total: registered lane value selected by the registered channel.
  // A lane only changes when it is the accepted channel, which also retags
  // out_ch, so this holds steady between acceptances.
  always_comb begin
    out_acc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (out_ch == CH_W'(i)) begin
        out_acc = lane_acc[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_accumulator.sv
module tb_multi_channel_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_ch = '0;
  logic [3:0] in_data = '0;
  logic       in_sub = 1'b0;
  logic       in_clr = 1'b0;
  logic       sat_en = 1'b0;
  logic       ovf_clr = 1'b0;

  logic       out_valid;
  logic [1:0] out_ch;
  logic [7:0] out_acc;
  logic [3:0] ovf;

  logic       b_out_valid;
  logic [1:0] b_out_ch;
  logic [7:0] b_out_acc;
  logic [2:0] b_ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock / reset
  always #5 clk = ~clk;

  multi_channel_accumulator #(.CHANNELS(4), .DATA_W(4), .ACC_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .in_sub(in_sub), .in_clr(in_clr), .sat_en(sat_en),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ch(out_ch),
    .out_acc(out_acc), .ovf(ovf)
  );

  // Three-channel instance: in_ch == 3 is out of range here.
  multi_channel_accumulator #(.CHANNELS(3), .DATA_W(4), .ACC_W(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .in_sub(in_sub), .in_clr(in_clr), .sat_en(sat_en),
    .ovf_clr(ovf_clr), .out_valid(b_out_valid), .out_ch(b_out_ch),
    .out_acc(b_out_acc), .ovf(b_ovf)
  );

  // Driver: present one cycle of inputs, wait past the edge, return to idle.
  task automatic step(input logic v, input logic [1:0] ch, input logic [3:0] d,
                      input logic sub, input logic clr, input logic sat,
                      input logic oclr);
    in_valid = v; in_ch = ch; in_data = d; in_sub = sub;
    in_clr = clr; sat_en = sat; ovf_clr = oclr;
    @(posedge clk);
    #1;
    in_valid = 1'b0; ovf_clr = 1'b0; in_clr = 1'b0;
  endtask

  // Clear a channel and build it up to a target value with wrapping adds.
  task automatic set_channel(input logic [1:0] ch, input int value);
    int rem;
    step(1, ch, 4'd0, 0, 1, 0, 0);
    rem = value;
    while (rem > 0) begin
      step(1, ch, (rem > 15) ? 4'd15 : 4'(rem), 0, 0, 0, 0);
      rem -= (rem > 15) ? 15 : rem;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_ch !== 2'd0) begin tests_failed++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
    tests_run++;
    if (out_acc !== 8'd0) begin tests_failed++; $display("FAIL reset_out_acc: got %0d expected 0", out_acc); end
    tests_run++;
    if (ovf !== 4'b0000) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0000", ovf); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_add();
    logic [3:0] d_vec [3];
    logic [7:0] e_vec [3];
    d_vec = '{4'd5, 4'd3, 4'd15};
    e_vec = '{8'd5, 8'd8, 8'd23};
    for (int i = 0; i < 3; i++) begin
      step(1, 2'd0, d_vec[i], 0, 0, 0, 0);
      tests_run++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_acc !== e_vec[i]) begin
        tests_failed++;
        $display("FAIL basic_add_%0d: got v=%b ch=%0d acc=%0d expected v=1 ch=0 acc=%0d",
                 i, out_valid, out_ch, out_acc, e_vec[i]);
      end
    end
    tests_run++;
    if (ovf !== 4'b0000) begin tests_failed++; $display("FAIL basic_add_ovf: got %b expected 0000", ovf); end
  endtask

  task automatic test_add_overflow();
    set_channel(2'd1, 250);
    step(1, 2'd1, 4'd10, 0, 0, 0, 0);
    tests_run++;
    if (out_acc !== 8'd4 || ovf[1] !== 1'b1) begin
      tests_failed++; $display("FAIL add_wrap: got acc=%0d ovf1=%b expected acc=4 ovf1=1", out_acc, ovf[1]);
    end
    set_channel(2'd1, 250);
    tests_run++;
    if (ovf[1] !== 1'b0) begin tests_failed++; $display("FAIL clr_ovf1: got %b expected 0", ovf[1]); end
    step(1, 2'd1, 4'd10, 0, 0, 1, 0);
    tests_run++;
    if (out_acc !== 8'd255 || ovf[1] !== 1'b1) begin
      tests_failed++; $display("FAIL add_sat: got acc=%0d ovf1=%b expected acc=255 ovf1=1", out_acc, ovf[1]);
    end
    set_channel(2'd1, 250);
    step(1, 2'd1, 4'd5, 0, 0, 0, 0);
    tests_run++;
    if (out_acc !== 8'd255 || ovf[1] !== 1'b0) begin
      tests_failed++; $display("FAIL add_exact: got acc=%0d ovf1=%b expected acc=255 ovf1=0", out_acc, ovf[1]);
    end
  endtask

  task automatic test_sub_underflow();
    set_channel(2'd2, 3);
    step(1, 2'd2, 4'd5, 1, 0, 1, 0);
    tests_run++;
    if (out_ch !== 2'd2 || out_acc !== 8'd0 || ovf[2] !== 1'b1) begin
      tests_failed++; $display("FAIL sub_sat: got ch=%0d acc=%0d ovf2=%b expected ch=2 acc=0 ovf2=1", out_ch, out_acc, ovf[2]);
    end
    set_channel(2'd2, 3);
    step(1, 2'd2, 4'd5, 1, 0, 0, 0);
    tests_run++;
    if (out_acc !== 8'd254 || ovf[2] !== 1'b1) begin
      tests_failed++; $display("FAIL sub_wrap: got acc=%0d ovf2=%b expected acc=254 ovf2=1", out_acc, ovf[2]);
    end
    set_channel(2'd2, 3);
    step(1, 2'd2, 4'd3, 1, 0, 0, 0);
    tests_run++;
    if (out_acc !== 8'd0 || ovf[2] !== 1'b0) begin
      tests_failed++; $display("FAIL sub_exact: got acc=%0d ovf2=%b expected acc=0 ovf2=0", out_acc, ovf[2]);
    end
  endtask

  task automatic test_back_to_back();
    set_channel(2'd0, 0);
    set_channel(2'd3, 0);
    step(1, 2'd0, 4'd1, 0, 0, 0, 0);
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_acc !== 8'd1) begin
      tests_failed++; $display("FAIL b2b_ch0_first: got v=%b ch=%0d acc=%0d expected v=1 ch=0 acc=1", out_valid, out_ch, out_acc);
    end
    step(1, 2'd3, 4'd1, 0, 0, 0, 0);
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_acc !== 8'd1) begin
      tests_failed++; $display("FAIL b2b_ch3: got v=%b ch=%0d acc=%0d expected v=1 ch=3 acc=1", out_valid, out_ch, out_acc);
    end
    step(1, 2'd0, 4'd1, 0, 0, 0, 0);
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_acc !== 8'd2) begin
      tests_failed++; $display("FAIL b2b_ch0_second: got v=%b ch=%0d acc=%0d expected v=1 ch=0 acc=2", out_valid, out_ch, out_acc);
    end
    // Same channel on consecutive cycles must see the fresh total.
    step(1, 2'd0, 4'd4, 0, 0, 0, 0);
    step(1, 2'd0, 4'd6, 0, 0, 0, 0);
    tests_run++;
    if (out_acc !== 8'd12) begin
      tests_failed++; $display("FAIL b2b_same_ch: got acc=%0d expected 12", out_acc);
    end
  endtask

  task automatic test_idle_and_drop();
    // in_valid low with junk on the other inputs: no strobe, outputs hold.
    step(0, 2'd1, 4'd9, 1, 1, 1, 0);
    tests_run++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_acc !== 8'd12) begin
      tests_failed++; $display("FAIL idle_hold: got v=%b ch=%0d acc=%0d expected v=0 ch=0 acc=12", out_valid, out_ch, out_acc);
    end
    // in_ch=3 is dropped by the three-channel instance, accepted by the main one.
    step(1, 2'd3, 4'd0, 0, 0, 0, 0);
    tests_run++;
    if (b_out_valid !== 1'b0 || b_out_ch !== 2'd0 || b_out_acc !== 8'd12) begin
      tests_failed++; $display("FAIL drop_out_of_range: got v=%b ch=%0d acc=%0d expected v=0 ch=0 acc=12", b_out_valid, b_out_ch, b_out_acc);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_acc !== 8'd1) begin
      tests_failed++; $display("FAIL accept_ch3: got v=%b ch=%0d acc=%0d expected v=1 ch=3 acc=1", out_valid, out_ch, out_acc);
    end
  endtask

  task automatic test_ovf_collision();
    set_channel(2'd1, 250);
    set_channel(2'd2, 0);
    step(1, 2'd2, 4'd1, 1, 0, 0, 0);
    tests_run++;
    if (ovf !== 4'b0100) begin tests_failed++; $display("FAIL ovf_setup: got %b expected 0100", ovf); end
    step(1, 2'd1, 4'd10, 0, 0, 0, 1);
    tests_run++;
    if (ovf !== 4'b0010 || out_acc !== 8'd4) begin
      tests_failed++; $display("FAIL ovf_clr_collision: got ovf=%b acc=%0d expected ovf=0010 acc=4", ovf, out_acc);
    end
    step(1, 2'd1, 4'd9, 1, 1, 0, 0);
    tests_run++;
    if (ovf !== 4'b0000 || out_ch !== 2'd1 || out_acc !== 8'd0) begin
      tests_failed++; $display("FAIL in_clr_ch1: got ovf=%b ch=%0d acc=%0d expected ovf=0000 ch=1 acc=0", ovf, out_ch, out_acc);
    end
  endtask

  task automatic test_reset_mid_stream();
    set_channel(2'd2, 0);
    step(1, 2'd2, 4'd1, 1, 0, 0, 0);
    step(1, 2'd0, 4'd5, 0, 0, 0, 0);
    // Valid sample pending; reset arrives mid-cycle.
    in_valid = 1'b1; in_ch = 2'd2; in_data = 4'd5; in_sub = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_acc !== 8'd0 || ovf !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_async: got v=%b ch=%0d acc=%0d ovf=%b expected all 0", out_valid, out_ch, out_acc, ovf);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_release_valid: got %b expected 0", out_valid); end
    step(1, 2'd0, 4'd7, 0, 0, 0, 0);
    tests_run++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_acc !== 8'd7) begin
      tests_failed++; $display("FAIL post_reset_sample: got v=%b ch=%0d acc=%0d expected v=1 ch=0 acc=7", out_valid, out_ch, out_acc);
    end
    // Channel 2 was zeroed by reset as well.
    step(1, 2'd2, 4'd0, 0, 0, 0, 0);
    tests_run++;
    if (out_acc !== 8'd0) begin tests_failed++; $display("FAIL post_reset_ch2: got acc=%0d expected 0", out_acc); end
  endtask

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_add_overflow();
    test_sub_underflow();
    test_back_to_back();
    test_idle_and_drop();
    test_ovf_collision();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
